spi_master_tx: RTL and testbench
================================

// Module: spi_master_tx
// PURPOSE
// - Write-only SPI master: serialises a 32-bit word onto MOSI, MSB first, SPI mode 0 (CPOL=0, CPHA=0).
// - Generates sClk from the system clock and frames each word with an active-low chip select.
// - Sits between the system-clock processing logic and an external SPI slave, e.g. a DAC or display.
// - No MISO path.
// PARAMETERS
// - DATA_W   32  bits per frame; ToSPI width.
// - CLK_DIV  4   clk cycles per sClk half-period. Legal range >=1. sClk frequency = f_clk/(2*CLK_DIV).
// PORTS
// - clk     in   1       system clock; every register is clocked on its rising edge.
// - reset   in   1       synchronous, active-high reset.
// - ToSPI   in   DATA_W  word to send; sampled only when a frame starts.
// - enable  in   1       transfer request; level sensitive.
// - sClk    out  1       SPI serial clock; idles low.
// - MOSI    out  1       serial data out; valid on sClk rising edges.
// - SPI_CS  out  1       chip select, active low; idles high.
// BEHAVIOUR
// - One clock; reset is synchronous and active-high.
// - Reset is sampled on the clk edge.
//   - Next state: IDLE. Outputs: sClk=0, MOSI=0, SPI_CS=1.
//   - Shift register, bit counter and divider counter all clear to 0.
//   - Reset during a frame aborts the frame immediately, with no partial-word completion.
// - All outputs are registered, so there are no combinational paths from the inputs.
// - States: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE. Let D = CLK_DIV and edge E0 = the clk edge that leaves IDLE.
//   - IDLE: SPI_CS=1, sClk=0, MOSI=0.
//     - If enable=1 at an edge: latch ToSPI into the shift register, drive SPI_CS=0 and MOSI=ToSPI[DATA_W-1], go to SETUP.
//   - SETUP: wait D cycles, then sClk rises (first rising edge at E0+D). Go to SHIFT.
//   - SHIFT: sClk toggles every D cycles.
//     - Rise k (k=0..DATA_W-1) occurs at E0+D+2kD. Fall k occurs at E0+2D+2kD.
//     - MOSI advances to the next lower bit on each falling edge, except the last one.
//     - After the last fall (E0+2*DATA_W*D), MOSI holds bit 0. Go to HOLD.
//   - HOLD: sClk=0, SPI_CS=0 for D cycles.
//     - At E0+(2*DATA_W+1)*D: SPI_CS=1, MOSI=0. Go to GAP.
//   - GAP: SPI_CS=1 for D cycles (minimum CS-high time), then go to IDLE.
//     - A new frame starts at the first edge in IDLE where enable=1.
//     - A held-high enable therefore gives back-to-back frames separated by D+1 CS-high cycles.
// - With the defaults (DATA_W=32, D=4): SPI_CS is low for exactly 260 clk cycles per frame.
// - enable is ignored outside IDLE.
//   - Deasserting enable mid-frame does not abort the frame; the frame always completes.
// - ToSPI changes after E0 do not affect the frame in flight.
// - Exactly DATA_W sClk rising edges occur per frame. sClk is never high while SPI_CS=1.
// - reset and enable asserted on the same edge: reset wins, no frame starts.
// TESTING
// - Reset: reset=1 for 2 cycles with enable=1 -> SPI_CS=1, sClk=0, MOSI=0 throughout; no sClk edges.
// - Single frame: ToSPI=32'hB38F0F82, enable pulsed 1 cycle.
//   - Expect 32 sClk rises.
//   - Bits captured on the rises = 1011_0011_1000_1111_0000_1111_1000_0010.
//   - SPI_CS low for 260 cycles.
//   - Then SPI_CS=1, MOSI=0.
// - Back-to-back: enable held high, words 32'hFFFFFFFF then 32'h00000001 (ToSPI changed mid-frame 1).
//   - Frame 1 is all ones.
//   - Frame 2 reads 0x00000001.
//   - CS-high gap between frames = 5 cycles.
// - Mid-frame change: ToSPI=32'h80000000, enable=1 for 1 cycle.
//   - After 10 rises, set ToSPI=32'hFFFFFFFF and enable=0.
//   - Expect the captured word to be 0x80000000, with all 32 rises present.
// - Reset mid-frame: assert reset after 16 rises.
//   - The next edge gives SPI_CS=1, sClk=0, MOSI=0.
//   - A following enable with ToSPI=32'h12345678 produces a clean full frame reading 0x12345678.
// - Divider: CLK_DIV=1, ToSPI=32'hA5A5A5A5.
//   - sClk period = 2 clk cycles.
//   - Captured word = 0xA5A5A5A5.
//   - SPI_CS low for 65 cycles.

Source files
------------

// File: rtl/spi_master_tx.sv
// Write-only SPI master, mode 0 (CPOL=0, CPHA=0): shifts a DATA_W-bit word out MSB first,
// framed by an active-low chip select, with sClk derived from clk by a half-period divider.
module spi_master_tx #(
  parameter int DATA_W  = 32,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] ToSPI,
  input  logic              enable,
  output logic              sClk,
  output logic              MOSI,
  output logic              SPI_CS
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                sclk_q, sclk_d;
  logic                mosi_q, mosi_d;
  logic                cs_q, cs_d;
  logic                tick;

  // tick marks the last clk cycle of the current sClk half-period.
  assign tick = (div_cnt_q == DIV_LAST);

  always_comb begin
    // NOTE: every signal gets a default before the case, so no path can infer a latch.
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    cs_d      = cs_q;

    if (state_q == IDLE) begin
      div_cnt_d = '0;
    end else if (tick) begin
      div_cnt_d = '0;
    end else begin
      div_cnt_d = div_cnt_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        sclk_d = 1'b0;
        cs_d   = 1'b1;
        mosi_d = 1'b0;
        if (enable) begin
          shift_d   = ToSPI;
          mosi_d    = ToSPI[DATA_W-1];
          cs_d      = 1'b0;
          bit_cnt_d = '0;
          state_d   = SETUP;
        end
      end

      SETUP: begin
        if (tick) begin
          sclk_d  = 1'b1;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        if (tick) begin
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            // The final falling edge leaves bit 0 on MOSI through HOLD.
            if (bit_cnt_q == BIT_LAST) begin
              state_d = HOLD;
            end else begin
              shift_d   = shift_q << 1;
              mosi_d    = shift_q[DATA_W-2];
              bit_cnt_d = bit_cnt_q + BIT_W'(1);
            end
          end
        end
      end

      HOLD: begin
        if (tick) begin
          cs_d    = 1'b1;
          mosi_d  = 1'b0;
          state_d = GAP;
        end
      end

      GAP: begin
        if (tick) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        sclk_d  = 1'b0;
        cs_d    = 1'b1;
        mosi_d  = 1'b0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      cs_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      cs_q      <= cs_d;
    end
  end

  assign sClk   = sclk_q;
  assign MOSI   = mosi_q;
  assign SPI_CS = cs_q;

endmodule

// File: tb/tb_spi_master_tx.sv
// Bench for spi_master_tx: two instances (CLK_DIV=4 and CLK_DIV=1) observed by a frame monitor
// that rebuilds each word from sClk rises and measures CS timing.
module tb_spi_master_tx;

  localparam int DW = 32;
  localparam int D0 = 4;
  localparam int D1 = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  en = 2'b11;
  logic [31:0] tospi[2] = '{32'h0, 32'h0};
  logic [1:0]  sclk, mosi, cs;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  spi_master_tx #(.DATA_W(DW), .CLK_DIV(D0)) dut0 (
    .clk(clk), .reset(reset), .ToSPI(tospi[0]), .enable(en[0]),
    .sClk(sclk[0]), .MOSI(mosi[0]), .SPI_CS(cs[0])
  );

  spi_master_tx #(.DATA_W(DW), .CLK_DIV(D1)) dut1 (
    .clk(clk), .reset(reset), .ToSPI(tospi[1]), .enable(en[1]),
    .sClk(sclk[1]), .MOSI(mosi[1]), .SPI_CS(cs[1])
  );

  // Reference rules for a frame, from the protocol description.
  function automatic int div_of(input int i);
    return (i == 0) ? D0 : D1;
  endfunction
  function automatic int exp_low(input int i);
    return (2 * DW + 1) * div_of(i);
  endfunction

  // Frame monitor, sampled on the falling clk edge.
  int          cyc = 0;
  logic [1:0]  prev_sclk = 2'b00;
  logic [1:0]  prev_cs = 2'b11;
  logic [31:0] cap[2] = '{0, 0};
  logic [31:0] last_word[2] = '{0, 0};
  int rises[2] = '{0, 0};
  int low_len[2] = '{0, 0};
  int high_len[2] = '{0, 0};
  int last_rises[2] = '{0, 0};
  int last_low[2] = '{0, 0};
  int start_gap[2] = '{0, 0};
  int frames_done[2] = '{0, 0};
  int bad_sclk[2] = '{0, 0};
  int total_rises[2] = '{0, 0};
  int last_rise_cyc[2] = '{0, 0};
  int period[2] = '{0, 0};

  always @(negedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 2; i++) begin
      prev_sclk[i] <= sclk[i];
      prev_cs[i]   <= cs[i];
      if (sclk[i] && !prev_sclk[i]) begin
        total_rises[i]   <= total_rises[i] + 1;
        period[i]        <= cyc - last_rise_cyc[i];
        last_rise_cyc[i] <= cyc;
      end
      if (sclk[i] && cs[i]) bad_sclk[i] <= bad_sclk[i] + 1;
      if (prev_cs[i] && !cs[i]) begin
        start_gap[i] <= high_len[i];
        low_len[i]   <= 1;
        rises[i]     <= 0;
        cap[i]       <= '0;
      end else if (!cs[i]) begin
        low_len[i] <= low_len[i] + 1;
        if (sclk[i] && !prev_sclk[i]) begin
          cap[i]   <= {cap[i][30:0], mosi[i]};
          rises[i] <= rises[i] + 1;
        end
      end
      if (!prev_cs[i] && cs[i]) begin
        last_word[i]   <= cap[i];
        last_rises[i]  <= rises[i];
        last_low[i]    <= low_len[i];
        frames_done[i] <= frames_done[i] + 1;
        high_len[i]    <= 1;
      end else if (cs[i]) begin
        high_len[i] <= high_len[i] + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic start_frame(input int i, input logic [31:0] word);
    repeat (8) tick();
    tospi[i] = word;
    en[i] = 1'b1;
    tick();
    en[i] = 1'b0;
  endtask

  task automatic wait_frame(input int i, input int target, input string tag);
    int n = 0;
    while (frames_done[i] < target && n < 3000) begin
      tick();
      n++;
    end
    check(tag, frames_done[i], target);
  endtask

  task automatic wait_rises(input int i, input int target, input string tag);
    int n = 0;
    while (rises[i] < target && n < 3000) begin
      tick();
      n++;
    end
    check(tag, 32'(rises[i] >= target), 32'd1);
  endtask

  task automatic check_frame(input int i, input logic [31:0] word, input string tag);
    check({tag, "_word"}, last_word[i], word);
    check({tag, "_rises"}, last_rises[i], DW);
    check({tag, "_cs_low"}, last_low[i], exp_low(i));
    check({tag, "_period"}, period[i], 2 * div_of(i));
  endtask

  task automatic check_idle(input int i, input string tag);
    check({tag, "_cs"}, cs[i], 1'b1);
    check({tag, "_sclk"}, sclk[i], 1'b0);
    check({tag, "_mosi"}, mosi[i], 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int nf;
    logic [31:0] w;

    // Reset held with enable high: nothing may start.
    tick();
    check_idle(0, "rst0");
    check_idle(1, "rst0_d1");
    tick();
    check_idle(0, "rst1");
    reset = 1'b0;
    en = 2'b00;
    tick();
    check_idle(0, "rst_release");
    check("rst_no_edges", total_rises[0] + total_rises[1], 0);

    // Single frame.
    nf = frames_done[0];
    start_frame(0, 32'hB38F0F82);
    wait_frame(0, nf + 1, "single_done");
    check_frame(0, 32'hB38F0F82, "single");
    check_idle(0, "single_after");

    // Back-to-back with enable held; ToSPI changes mid-frame 1.
    repeat (8) tick();
    nf = frames_done[0];
    tospi[0] = 32'hFFFFFFFF;
    en[0] = 1'b1;
    repeat (100) tick();
    tospi[0] = 32'h00000001;
    wait_frame(0, nf + 1, "b2b1_done");
    check_frame(0, 32'hFFFFFFFF, "b2b1");
    for (int n = 0; n < 20 && cs[0]; n++) tick();
    en[0] = 1'b0;
    wait_frame(0, nf + 2, "b2b2_done");
    check_frame(0, 32'h00000001, "b2b2");
    check("b2b_gap", start_gap[0], D0 + 1);

    // ToSPI and enable change mid-frame: frame in flight unaffected.
    nf = frames_done[0];
    start_frame(0, 32'h80000000);
    wait_rises(0, 10, "mid_rises10");
    tospi[0] = 32'hFFFFFFFF;
    wait_frame(0, nf + 1, "mid_done");
    check_frame(0, 32'h80000000, "mid");

    // Reset mid-frame aborts immediately; next frame is clean.
    start_frame(0, $urandom);
    wait_rises(0, 16, "abort_rises16");
    reset = 1'b1;
    tick();
    check_idle(0, "abort");
    reset = 1'b0;
    nf = frames_done[0];
    start_frame(0, 32'h12345678);
    wait_frame(0, nf + 1, "post_abort_done");
    check_frame(0, 32'h12345678, "post_abort");

    // Random words on both dividers.
    for (int k = 0; k < 4; k++) begin
      w = $urandom;
      nf = frames_done[0];
      start_frame(0, w);
      wait_frame(0, nf + 1, "rand0_done");
      check_frame(0, w, "rand0");
    end

    nf = frames_done[1];
    start_frame(1, 32'hA5A5A5A5);
    wait_frame(1, nf + 1, "div1_done");
    check_frame(1, 32'hA5A5A5A5, "div1");
    check_idle(1, "div1_after");
    for (int k = 0; k < 3; k++) begin
      w = $urandom;
      nf = frames_done[1];
      start_frame(1, w);
      wait_frame(1, nf + 1, "rand1_done");
      check_frame(1, w, "rand1");
    end

    check("sclk_high_cs_high_0", bad_sclk[0], 0);
    check("sclk_high_cs_high_1", bad_sclk[1], 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
